// File: rtl/wb_arch_regs_pkg.sv
// wb_arch_regs_pkg: shared widths and reset polarity for the write-back architectural state
package wb_arch_regs_pkg;
  localparam int REG_BUS_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/wb_arch_regs_regfile_bank.sv
// regfile_bank: GPR array with one write port, two raw async read ports, $0 write suppression
module regfile_bank
  import wb_arch_regs_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (rst == RST_ACTIVE) mem <= '{default: '0};
    else if (we && waddr != '0) mem[waddr] <= wdata;
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/wb_arch_regs.sv
// wb_arch_regs: write-back architectural state (GPRs with read bypass, HI/LO, FLAGS, retire counter)
module wb_arch_regs
  import wb_arch_regs_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_flags,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] flags_o,
  output logic [DATA_W-1:0] wb_count
);
  logic              rst_on;
  logic              retire;
  logic [DATA_W-1:0] raw1, raw2;
  assign rst_on = rst == RST_ACTIVE;
  assign retire = wb_wreg || wb_we;
  regfile_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );
  // The array updates at the edge, so a same-cycle write must be forwarded here
  always_comb begin
    rdata1 = (rst_on || !re1 || raddr1 == '0) ? '0 : (wb_wreg && wb_wd == raddr1) ? wb_wdata : raw1;
    rdata2 = (rst_on || !re2 || raddr2 == '0) ? '0 : (wb_wreg && wb_wd == raddr2) ? wb_wdata : raw2;
  end
  always_ff @(posedge clk)
    if (rst_on) begin
      hi_o     <= '0;
      lo_o     <= '0;
      flags_o  <= '0;
      wb_count <= '0;
    end else begin
      if (wb_we) begin
        hi_o <= wb_hi;
        lo_o <= wb_lo;
      end
      if (retire) begin
        flags_o  <= wb_flags;
        wb_count <= wb_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_wb_arch_regs.sv
// tb_wb_arch_regs: directed and randomized checks of wb_arch_regs against a behavioural model
module tb_wb_arch_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  wb_wd = '0;
  logic        wb_wreg = 1'b0;
  logic [31:0] wb_wdata = '0, wb_hi = '0, wb_lo = '0, wb_flags = '0;
  logic        wb_we = 1'b0;
  logic        re1 = 1'b0, re2 = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, flags_o, wb_count;
  logic        n_rst = 1'b0;
  logic        n_wreg = 1'b0;
  logic [7:0]  n_rdata1, n_rdata2, n_hi, n_lo, n_flags, n_count;
  int passed = 0;
  int total = 0;
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_flags, m_cnt;

  always #5 clk = ~clk;

  wb_arch_regs dut (
    .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_we(wb_we), .wb_flags(wb_flags),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .flags_o(flags_o), .wb_count(wb_count)
  );

  // Narrow instance so the counter wrap is reachable in a few hundred cycles
  wb_arch_regs #(.DATA_W(8), .ADDR_W(5)) dut_n (
    .clk(clk), .rst(n_rst), .wb_wd(5'd1), .wb_wreg(n_wreg), .wb_wdata(8'h3C),
    .wb_hi(8'h0), .wb_lo(8'h0), .wb_we(1'b0), .wb_flags(8'h0),
    .re1(1'b0), .raddr1(5'd0), .rdata1(n_rdata1), .re2(1'b0), .raddr2(5'd0), .rdata2(n_rdata2),
    .hi_o(n_hi), .lo_o(n_lo), .flags_o(n_flags), .wb_count(n_count)
  );

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (!rst || !re || a == 5'd0) return 32'h0;
    if (wb_wreg && wb_wd == a) return wb_wdata;
    return m_gpr[a];
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      foreach (m_gpr[i]) m_gpr[i] = 32'h0;
      m_hi = 0; m_lo = 0; m_flags = 0; m_cnt = 0;
    end else begin
      if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
      if (wb_we) begin m_hi = wb_hi; m_lo = wb_lo; end
      if (wb_wreg || wb_we) begin m_flags = wb_flags; m_cnt = m_cnt + 1; end
    end
    #1;
  endtask

  task automatic idle();
    wb_wreg = 0; wb_we = 0;
  endtask

  task automatic test_reset();
    rst = 0; re1 = 1; raddr1 = 5'd5;
    wb_wreg = 1; wb_wd = 5'd5; wb_wdata = 32'h11;
    cycle(); cycle(); #1;
    total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 got %h want 0", rdata1); else passed++;
    total++; if (hi_o !== 32'h0) $display("FAIL reset_hi got %h want 0", hi_o); else passed++;
    total++; if (lo_o !== 32'h0) $display("FAIL reset_lo got %h want 0", lo_o); else passed++;
    total++; if (flags_o !== 32'h0) $display("FAIL reset_flags got %h want 0", flags_o); else passed++;
    total++; if (wb_count !== 32'h0) $display("FAIL reset_count got %h want 0", wb_count); else passed++;
    idle(); rst = 1; cycle();
  endtask

  task automatic test_write_read();
    wb_wreg = 1; wb_wd = 5'd3; wb_wdata = 32'hDEADBEEF; re1 = 1; raddr1 = 5'd3; #1;
    total++; if (rdata1 !== 32'hDEADBEEF) $display("FAIL bypass_rd1 got %h want deadbeef", rdata1); else passed++;
    cycle(); idle(); #1;
    total++; if (rdata1 !== 32'hDEADBEEF) $display("FAIL array_rd1 got %h want deadbeef", rdata1); else passed++;
  endtask

  task automatic test_zero_reg();
    logic [31:0] c0;
    c0 = m_cnt;
    wb_wreg = 1; wb_wd = 5'd0; wb_wdata = 32'h1234; re1 = 1; re2 = 1; raddr1 = 0; raddr2 = 0; #1;
    total++; if (rdata1 !== 32'h0) $display("FAIL zero_rd1_same got %h want 0", rdata1); else passed++;
    total++; if (rdata2 !== 32'h0) $display("FAIL zero_rd2_same got %h want 0", rdata2); else passed++;
    cycle(); idle(); #1;
    total++; if (rdata1 !== 32'h0) $display("FAIL zero_rd1_next got %h want 0", rdata1); else passed++;
    total++; if (rdata2 !== 32'h0) $display("FAIL zero_rd2_next got %h want 0", rdata2); else passed++;
    total++; if (wb_count !== c0 + 32'd1) $display("FAIL zero_count got %h want %h", wb_count, c0 + 32'd1); else passed++;
  endtask

  task automatic test_hilo_bubble();
    logic [31:0] c0;
    wb_we = 1; wb_hi = 32'h1; wb_lo = 32'h2; wb_flags = 32'h8;
    cycle(); idle();
    c0 = m_cnt;
    total++; if (hi_o !== 32'h1) $display("FAIL hi_write got %h want 1", hi_o); else passed++;
    total++; if (lo_o !== 32'h2) $display("FAIL lo_write got %h want 2", lo_o); else passed++;
    total++; if (flags_o !== 32'h8) $display("FAIL flags_write got %h want 8", flags_o); else passed++;
    wb_flags = 32'h0;
    cycle();
    total++; if (flags_o !== 32'h8) $display("FAIL bubble_flags got %h want 8", flags_o); else passed++;
    total++; if (wb_count !== c0) $display("FAIL bubble_count got %h want %h", wb_count, c0); else passed++;
  endtask

  task automatic test_enable_bypass();
    re2 = 0; raddr2 = 5'd3; #1;
    total++; if (rdata2 !== 32'h0) $display("FAIL re2_off got %h want 0", rdata2); else passed++;
    wb_wreg = 1; wb_wd = 5'd7; wb_wdata = 32'hA5; re1 = 1; re2 = 1; raddr1 = 5'd7; raddr2 = 5'd7; #1;
    total++; if (rdata1 !== 32'hA5) $display("FAIL dual_bypass_rd1 got %h want a5", rdata1); else passed++;
    total++; if (rdata2 !== 32'hA5) $display("FAIL dual_bypass_rd2 got %h want a5", rdata2); else passed++;
    cycle(); idle();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      wb_wreg = $urandom_range(0, 1); wb_we = $urandom_range(0, 2) == 0;
      wb_wd = $urandom_range(0, 31); wb_wdata = $urandom; wb_hi = $urandom; wb_lo = $urandom; wb_flags = $urandom;
      re1 = $urandom_range(0, 7) != 0; re2 = $urandom_range(0, 7) != 0;
      raddr1 = $urandom_range(0, 1) ? wb_wd : 5'($urandom_range(0, 31));
      raddr2 = $urandom_range(0, 1) ? raddr1 : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_rd(re1, raddr1); e2 = exp_rd(re2, raddr2);
      total++; if (rdata1 !== e1) $display("FAIL rand_rd1 n=%0d got %h want %h", n, rdata1, e1); else passed++;
      total++; if (rdata2 !== e2) $display("FAIL rand_rd2 n=%0d got %h want %h", n, rdata2, e2); else passed++;
      cycle();
      total++; if (hi_o !== m_hi || lo_o !== m_lo) $display("FAIL rand_hilo n=%0d got %h/%h want %h/%h", n, hi_o, lo_o, m_hi, m_lo); else passed++;
      total++; if (flags_o !== m_flags) $display("FAIL rand_flags n=%0d got %h want %h", n, flags_o, m_flags); else passed++;
      total++; if (wb_count !== m_cnt) $display("FAIL rand_count n=%0d got %h want %h", n, wb_count, m_cnt); else passed++;
    end
    rst = 1; idle(); cycle();
  endtask

  task automatic test_wrap_and_reset();
    n_rst = 1; n_wreg = 1;
    for (int n = 0; n < 255; n++) cycle();
    total++; if (n_count !== 8'hFF) $display("FAIL wrap_full got %h want ff", n_count); else passed++;
    cycle(); n_wreg = 0;
    total++; if (n_count !== 8'h00) $display("FAIL wrap_zero got %h want 00", n_count); else passed++;
    wb_wreg = 1; wb_wd = 5'd9; wb_wdata = 32'h77; cycle();
    rst = 0; wb_wdata = 32'h5555; cycle();
    rst = 1; idle(); re1 = 1; raddr1 = 5'd9; #1;
    total++; if (rdata1 !== 32'h0) $display("FAIL reset_drops_write got %h want 0", rdata1); else passed++;
    total++; if (wb_count !== 32'h0) $display("FAIL reset_mid_count got %h want 0", wb_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_hilo_bubble();
    test_enable_bypass();
    test_random();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
